// File: rtl/serv_bufreg_pkg.sv
// Shared encodings and sizing helpers for the SERV buffer register.
package serv_bufreg_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   function automatic int cnt_w(input int steps);
      return (steps <= 1) ? 1 : $clog2(steps);
   endfunction

endpackage

// File: rtl/serv_bufreg_add.sv
// W-bit slice adder with carry in/out and optional clear of operand-b bit 0.
module serv_bufreg_add #(
   parameter int W = 1
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         clr_i,
   input  logic         cin_i,
   output logic [W-1:0] s_o,
   output logic         c_o
);

   logic [W-1:0] b_m;

   always_comb begin
      b_m    = b_i;
      b_m[0] = b_i[0] & ~clr_i;
   end

   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_m} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/serv_bufreg_par.sv
// W-bit-per-step buffer register: serial rs1+imm adder feeding an XLEN
// shift buffer that provides the data-bus address and misalign flag.
module serv_bufreg_par
   import serv_bufreg_pkg::*;
#(
   parameter int W    = 1,
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_en,
   input  logic            i_init,
   input  logic            i_loop,
   input  logic [W-1:0]    i_rs1,
   input  logic            i_rs1_en,
   input  logic [W-1:0]    i_imm,
   input  logic            i_imm_en,
   input  logic            i_clr_lsb,
   input  logic [1:0]      i_size,
   output logic [W-1:0]    o_q,
   output logic [XLEN-1:0] o_dbus_adr,
   output logic [1:0]      o_lsb,
   output logic            o_misalign,
   output logic            o_busy,
   output logic            o_last
);

   localparam int N  = XLEN / W;
   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [XLEN-1:0] buf_q, buf_d;
   logic [CW-1:0]   step_q, step_d, cur_step;
   logic            busy_q, busy_d;
   logic            c_q, c_d;
   logic [1:0]      lsb_q, lsb_d;

   logic            eff;
   logic            cin;
   logic            sum_c;
   logic [W-1:0]    sum_s;
   logic [1:0]      s2;
   logic [W-1:0]    d;

   // A start pulse restarts the pass, so it overrides the live counter/carry.
   assign eff      = i_en & (busy_q | i_start);
   assign cur_step = i_start ? '0 : step_q;
   assign cin      = i_start ? 1'b0 : c_q;

   serv_bufreg_add #(.W(W)) u_add (
      .a_i   (i_rs1 & {W{i_rs1_en}}),
      .b_i   (i_imm & {W{i_imm_en}}),
      .clr_i (i_clr_lsb & (cur_step == '0)),
      .cin_i (cin),
      .s_o   (sum_s),
      .c_o   (sum_c)
   );

   assign s2 = 2'(sum_s);
   assign d  = (!i_init && i_loop) ? buf_q[W-1:0] : sum_s;

   always_comb begin
      buf_d  = buf_q;
      step_d = step_q;
      busy_d = busy_q;
      c_d    = c_q;
      lsb_d  = lsb_q;
      if (i_start) begin
         step_d = '0;
         busy_d = 1'b1;
         c_d    = 1'b0;
      end
      if (eff) begin
         c_d   = sum_c & i_init;
         buf_d = {d, buf_q[XLEN-1:W]};
         if (cur_step == LAST) begin
            step_d = '0;
            if (!i_start) busy_d = 1'b0;
         end else begin
            step_d = cur_step + 1'b1;
         end
         if (i_init) begin
            if (W >= 2) begin
               if (cur_step == '0) lsb_d = s2;
            end else begin
               if (cur_step == CW'(0)) lsb_d[0] = s2[0];
               if (cur_step == CW'(1)) lsb_d[1] = s2[0];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         buf_q  <= '0;
         step_q <= '0;
         busy_q <= 1'b0;
         c_q    <= 1'b0;
         lsb_q  <= 2'b00;
      end else begin
         buf_q  <= buf_d;
         step_q <= step_d;
         busy_q <= busy_d;
         c_q    <= c_d;
         lsb_q  <= lsb_d;
      end
   end

   assign o_q        = buf_q[W-1:0];
   assign o_dbus_adr = {buf_q[XLEN-1:2], 2'b00};
   assign o_lsb      = lsb_q;
   assign o_busy     = busy_q;
   assign o_last     = busy_q & (step_q == LAST);
   assign o_misalign = ((i_size == SIZE_H) & lsb_q[0]) |
                       (i_size[1] & (|lsb_q));

endmodule

// File: doc/serv_bufreg_par.md
# serv_bufreg_par

Parametrised bit-serial/nibble-serial buffer register for the SERV datapath. It adds rs1 and immediate operands W bits per step with a registered carry. The sum is shifted into an XLEN-bit buffer that drives the data-bus address. Beyond the 1-bit generation, it adds an internal step counter with pass start/last tracking, W-wide operation, and load/store misalignment detection from the captured address LSBs.

## Interface
Parameters:
- W, 1, bits processed per step; legal values 1, 2, 4, 8.
- XLEN, 32, buffer width; must be a multiple of W and at least 4.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that begins a pass.
- i_en  in  1  step enable.
- i_init  in  1  1 = compute pass (load the sum); 0 = shift pass.
- i_loop  in  1  in a shift pass, recirculate o_q into the MSBs.
- i_rs1  in  W  rs1 slice, LSB first.
- i_rs1_en  in  1  gates i_rs1.
- i_imm  in  W  immediate slice, LSB first.
- i_imm_en  in  1  gates i_imm.
- i_clr_lsb  in  1  force address bit 0 of the immediate to 0 (JALR).
- i_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- o_q  out  W  buffer[W-1:0].
- o_dbus_adr  out  XLEN  {buffer[XLEN-1:2], 2'b00}.
- o_lsb  out  2  captured sum bits [1:0].
- o_misalign  out  1  (i_size==01 & o_lsb[0]) | (i_size[1] & |o_lsb); combinational.
- o_busy  out  1  pass in progress.
- o_last  out  1  o_busy & step==XLEN/W-1.

## Operation
- **Step counter:** width clog2(XLEN/W).
  - step advances on an effective step: i_en & (o_busy | i_start).
  - i_en while idle without i_start is ignored: no shift, no count, no carry update.
- **i_start:**
  - Forces carry-in to 0, step to 0 and o_busy to 1.
  - If i_en is also high in that cycle, step 0 is processed in that same cycle and step becomes 1.
  - i_start while busy restarts the pass. Buffer contents are kept; counter and carry are cleared.
- **Adder:** {c, s} = (i_rs1 & {W{i_rs1_en}}) + (imm_m & {W{i_imm_en}}) + cin.
  - imm_m equals i_imm with bit 0 cleared when step==0 & i_clr_lsb.
  - cin = i_start ? 0 : c_r.
- **Carry:** on an effective step, c_r <= c & i_init.
- **Shift:** on an effective step, buffer <= {d, buffer[XLEN-1:W]}.
  - d = s when i_init.
  - d = o_q when !i_init & i_loop.
  - d = s otherwise (shift pass without loop loads the ungated adder output, normally 0).
- **LSB capture:** only on effective steps with i_init.
  - W>=2: step 0 writes o_lsb <= s[1:0].
  - W=1: step 0 writes o_lsb[0]; step 1 writes o_lsb[1].
- **Pass end:** an effective step at step==XLEN/W-1 clears o_busy and wraps step to 0. If i_start is asserted in the same cycle, i_start wins.
- **Reset values:** buffer, c_r, step, o_busy and o_lsb all 0. Consequently o_q=0, o_dbus_adr=0, o_last=0 and o_misalign=0. Reset mid-pass aborts the pass.

## Timing
- A full pass takes XLEN/W effective steps. With i_en held high from i_start, that is XLEN/W cycles.
- o_dbus_adr is valid the cycle after the last step. o_busy falls in that same cycle.
- o_lsb is valid one cycle after step 1 (W=1) or step 0 (W>=2). o_misalign follows combinationally.
- Gaps in i_en stall the pass; state is held and o_last holds during a stall.
- o_q is registered with zero combinational path from inputs. o_misalign is combinational from i_size.

## Structure
- **Package serv_bufreg_pkg** holds:
  - size encodings SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - a function computing the counter width from XLEN/W.
- **Sub-module serv_bufreg_add** is a W-bit adder with carry-in/out and the bit-0 clear mask. It is instantiated once.
- The counter and the misalign logic stay inline.

## Test plan
- W=1, i_start then 32 steps with i_init=1, rs1=0x00001000, imm=0x24 -> o_dbus_adr=0x00001024, o_lsb=00, o_busy falls after step 31.
- W=4, rs1=0x2, imm=0x1, i_size=01 -> o_lsb=11, o_misalign=1; with i_size=00 -> o_misalign=0.
- W=2, rs1=0x100, imm=0x7, i_clr_lsb=1 -> o_dbus_adr=0x104, o_lsb=10.
- W=8, load 0xA5A5F00F, then shift pass with i_loop=1 over 4 steps -> buffer returns to 0xA5A5F00F; o_q sequence 0x0F, 0xF0, 0xA5, 0xA5.
- i_en gaps and idle i_en: 10-cycle stall mid-pass -> same result as the unstalled pass. i_en while idle -> buffer unchanged.
- i_start at step 5 -> counter restarts and carry clears; i_rst at step 3 -> all outputs 0 next cycle, o_busy=0.
